// File: rtl/stream_mux_nx1_pkg.sv
// ============================================================================
// Module      : stream_mux_nx1_pkg
// Description : Shared mode constants and FSM state type for stream_mux_nx1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package stream_mux_nx1_pkg;

    localparam int MODE_SELECT = 0;
    localparam int MODE_RR     = 1;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/stream_mux_nx1_rr_arbiter.sv
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker: first requester at or above
//               ptr, wrapping to channel 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  gnt_idx,
    output logic              gnt_any
);

    logic w_found;

    always_comb begin
        gnt_idx = ptr;
        w_found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            int j;
            j = int'(ptr) + i;
            if (j >= NUM_CH) begin
                j = j - NUM_CH;
            end
            if (!w_found && req[j]) begin
                w_found = 1'b1;
                gnt_idx = SEL_W'(j);
            end
        end
    end

    assign gnt_any = |req;

endmodule

`default_nettype wire

// File: rtl/stream_mux_nx1.sv
// ============================================================================
// Module      : stream_mux_nx1
// Description : N-to-1 registered stream mux with packet locking and either
//               port-selected or round-robin channel arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_mux_nx1
    import stream_mux_nx1_pkg::*;
#(
    parameter  int DATAWIDTH = 8,
    parameter  int NUM_CH    = 4,
    parameter  int MODE      = MODE_SELECT,
    localparam int SEL_W     = $clog2(NUM_CH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CH*DATAWIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]           in_valid,
    input  logic [NUM_CH-1:0]           in_last,
    output logic [NUM_CH-1:0]           in_ready,
    input  logic [SEL_W-1:0]            sel,
    output logic [DATAWIDTH-1:0]        out_data,
    output logic                        out_valid,
    output logic                        out_last,
    output logic [SEL_W-1:0]            out_ch,
    input  logic                        out_ready
);

    state_t               r_state;
    logic [SEL_W-1:0]     r_lock_ch;
    logic [SEL_W-1:0]     r_rr_ptr;

    logic [SEL_W-1:0]     w_rr_idx;
    logic                 w_rr_any;
    logic [SEL_W-1:0]     w_grant;
    logic                 w_grant_ok;
    logic                 w_can_load;
    logic                 w_accept;
    logic [NUM_CH-1:0]    w_in_ready;
    logic [DATAWIDTH-1:0] w_beat_data;
    logic                 w_beat_last;
    logic                 w_beat_valid;

    generate
        if (MODE == MODE_RR) begin : g_rr
            rr_arbiter #(
                .NUM_CH (NUM_CH),
                .SEL_W  (SEL_W)
            ) u_rr_arbiter (
                .req     (in_valid),
                .ptr     (r_rr_ptr),
                .gnt_idx (w_rr_idx),
                .gnt_any (w_rr_any)
            );
        end else begin : g_no_rr
            assign w_rr_idx = r_rr_ptr;
            assign w_rr_any = 1'b0;
        end
    endgenerate

    assign w_can_load = !out_valid | out_ready;

    always_comb begin
        w_grant    = sel;
        w_grant_ok = 1'b0;
        if (r_state == ST_LOCKED) begin
            w_grant    = r_lock_ch;
            w_grant_ok = 1'b1;
        end else if (MODE == MODE_RR) begin
            w_grant    = w_rr_idx;
            w_grant_ok = w_rr_any;
        end else begin
            // Out-of-range select on non-power-of-two channel counts grants nothing
            w_grant    = sel;
            w_grant_ok = ({1'b0, sel} < (SEL_W+1)'(NUM_CH));
        end
    end

    always_comb begin
        w_in_ready   = '0;
        w_beat_data  = '0;
        w_beat_last  = 1'b0;
        w_beat_valid = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (SEL_W'(k) == w_grant) begin
                w_beat_data   = in_data[k*DATAWIDTH +: DATAWIDTH];
                w_beat_last   = in_last[k];
                w_beat_valid  = in_valid[k];
                w_in_ready[k] = w_can_load & w_grant_ok & rst_n;
            end
        end
    end

    assign in_ready = w_in_ready;
    assign w_accept = w_beat_valid & w_can_load & w_grant_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_ch    <= '0;
            r_state   <= ST_IDLE;
            r_lock_ch <= '0;
            r_rr_ptr  <= '0;
        end else begin
            if (w_accept) begin
                out_data  <= w_beat_data;
                out_last  <= w_beat_last;
                out_ch    <= w_grant;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_accept && !w_beat_last) begin
                        r_state   <= ST_LOCKED;
                        r_lock_ch <= w_grant;
                    end
                end
                ST_LOCKED: begin
                    if (w_accept && w_beat_last) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if ((MODE == MODE_RR) && w_accept && w_beat_last) begin
                r_rr_ptr <= (w_grant == SEL_W'(NUM_CH-1)) ? '0 : w_grant + SEL_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_stream_mux_nx1.sv
// Bench for stream_mux_nx1: three instances (select/4ch, round-robin/4ch,
// select/3ch) checked every cycle against a transaction-level model.
`default_nettype none

module tb_stream_mux_nx1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] ind  [3];
    logic [3:0]  inv  [3];
    logic [3:0]  inl  [3];
    logic [1:0]  sel  [3];
    logic        ordy [3];

    logic [3:0]  irdy [3];
    logic [7:0]  od   [3];
    logic        ov   [3];
    logic        ol   [3];
    logic [1:0]  och  [3];

    logic [3:0] rdy0, rdy1;
    logic [2:0] rdy2;
    logic [7:0] od0, od1, od2;
    logic       ov0, ov1, ov2, ol0, ol1, ol2;
    logic [1:0] och0, och1, och2;

    stream_mux_nx1 #(.DATAWIDTH(8), .NUM_CH(4), .MODE(0)) u_sel4 (
        .clk(clk), .rst_n(rst_n), .in_data(ind[0]), .in_valid(inv[0]),
        .in_last(inl[0]), .in_ready(rdy0), .sel(sel[0]), .out_data(od0),
        .out_valid(ov0), .out_last(ol0), .out_ch(och0), .out_ready(ordy[0]));

    stream_mux_nx1 #(.DATAWIDTH(8), .NUM_CH(4), .MODE(1)) u_rr4 (
        .clk(clk), .rst_n(rst_n), .in_data(ind[1]), .in_valid(inv[1]),
        .in_last(inl[1]), .in_ready(rdy1), .sel(sel[1]), .out_data(od1),
        .out_valid(ov1), .out_last(ol1), .out_ch(och1), .out_ready(ordy[1]));

    stream_mux_nx1 #(.DATAWIDTH(8), .NUM_CH(3), .MODE(0)) u_sel3 (
        .clk(clk), .rst_n(rst_n), .in_data(ind[2][23:0]), .in_valid(inv[2][2:0]),
        .in_last(inl[2][2:0]), .in_ready(rdy2), .sel(sel[2]), .out_data(od2),
        .out_valid(ov2), .out_last(ol2), .out_ch(och2), .out_ready(ordy[2]));

    always_comb begin
        irdy[0] = rdy0; irdy[1] = rdy1; irdy[2] = {1'b0, rdy2};
        od[0]   = od0;  od[1]   = od1;  od[2]   = od2;
        ov[0]   = ov0;  ov[1]   = ov1;  ov[2]   = ov2;
        ol[0]   = ol0;  ol[1]   = ol1;  ol[2]   = ol2;
        och[0]  = och0; och[1]  = och1; och[2]  = och2;
    end

    int vectors = 0;
    int miscompares = 0;

    // Reference: open packet owner (-1 = none), rotation pointer, and the one
    // beat the consumer is still owed.
    int         lock [3];
    int         rr   [3];
    bit         ev   [3];
    logic [7:0] ed   [3];
    bit         el   [3];
    int         ech  [3];
    int         log0 [$];
    int         log1 [$];

    function automatic int nch(int k);
        return (k == 2) ? 3 : 4;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        for (int k = 0; k < 3; k++) begin
            ind[k] = '0; inv[k] = '0; inl[k] = '0; sel[k] = '0; ordy[k] = 1'b1;
        end
    endtask

    task automatic tick();
        int   g   [3];
        bit   acc [3];
        bit   oxf [3];
        bit   ok, can, found;
        logic [3:0] er;
        #1;
        for (int k = 0; k < 3; k++) begin
            can = !ev[k] || ordy[k];
            if (lock[k] >= 0) begin
                g[k] = lock[k]; ok = 1'b1;
            end else if (k == 1) begin
                ok = |inv[k]; g[k] = rr[k]; found = 1'b0;
                for (int i = 0; i < nch(k); i++) begin
                    if (!found && inv[k][(rr[k] + i) % nch(k)]) begin
                        found = 1'b1; g[k] = (rr[k] + i) % nch(k);
                    end
                end
            end else begin
                g[k] = int'(sel[k]); ok = (g[k] < nch(k));
            end
            er = (can && ok) ? (4'b0001 << g[k]) : 4'b0000;
            chk($sformatf("in_ready[u%0d]", k), 32'(irdy[k]), 32'(er));
            chk($sformatf("out_valid[u%0d]", k), 32'(ov[k]), 32'(ev[k]));
            if (ev[k]) begin
                chk($sformatf("out_data[u%0d]", k), 32'(od[k]), 32'(ed[k]));
                chk($sformatf("out_last[u%0d]", k), 32'(ol[k]), 32'(el[k]));
                chk($sformatf("out_ch[u%0d]", k), 32'(och[k]), 32'(ech[k]));
            end
            acc[k] = can && ok && inv[k][g[k]];
            oxf[k] = ev[k] && ordy[k];
            if (oxf[k] && k == 0) log0.push_back(ech[k]);
            if (oxf[k] && k == 1) log1.push_back(ech[k]);
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (acc[k]) begin
                ev[k] = 1'b1; ed[k] = ind[k][g[k]*8 +: 8]; el[k] = inl[k][g[k]]; ech[k] = g[k];
                if (el[k]) begin
                    lock[k] = -1; rr[k] = (g[k] + 1) % nch(k);
                end else begin
                    lock[k] = g[k];
                end
            end else if (oxf[k]) begin
                ev[k] = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_out_valid[u%0d]", k), 32'(ov[k]), 32'd0);
            chk($sformatf("rst_out_data[u%0d]", k), 32'(od[k]), 32'd0);
            chk($sformatf("rst_out_last[u%0d]", k), 32'(ol[k]), 32'd0);
            chk($sformatf("rst_out_ch[u%0d]", k), 32'(och[k]), 32'd0);
            chk($sformatf("rst_in_ready[u%0d]", k), 32'(irdy[k]), 32'd0);
            ev[k] = 1'b0; lock[k] = -1; rr[k] = 0; ed[k] = '0; el[k] = 1'b0; ech[k] = 0;
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] held;
        rst_n = 1'b1;
        clr();
        @(negedge clk);
        do_reset();

        // Single-beat on channel 2 by select
        sel[0] = 2'd2; ind[0][23:16] = 8'hA5; inv[0] = 4'b0100; inl[0] = 4'b0100;
        #1 chk("a5_in_ready", 32'(irdy[0]), 32'b0100);
        tick();
        chk("a5_out_data", 32'(od[0]), 32'hA5);
        chk("a5_out_ch", 32'(och[0]), 32'd2);
        chk("a5_out_last", 32'(ol[0]), 32'd1);
        clr();
        tick();

        // Locked 3-beat packet on ch1 while sel moves to ch3
        log0.delete();
        sel[0] = 2'd1; inv[0] = 4'b0010; ind[0][15:8] = 8'h11;
        tick();
        sel[0] = 2'd3; inv[0] = 4'b1010; inl[0] = 4'b1000; ind[0][15:8] = 8'h22; ind[0][31:24] = 8'h77;
        tick();
        inl[0] = 4'b1010; ind[0][15:8] = 8'h33;
        tick();
        inv[0] = 4'b1000;
        tick();
        clr();
        tick();
        chk("lock_seq_len", 32'(log0.size()), 32'd4);
        chk("lock_seq0", 32'(log0[0]), 32'd1);
        chk("lock_seq1", 32'(log0[1]), 32'd1);
        chk("lock_seq2", 32'(log0[2]), 32'd1);
        chk("lock_seq3", 32'(log0[3]), 32'd3);

        // Backpressure hold then full-rate resume
        inv[0] = 4'b0001; inl[0] = 4'b0001; ind[0][7:0] = 8'h5C;
        tick();
        held = od[0];
        ordy[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ind[0][7:0] = 8'(8'h60 + i);
            tick();
        end
        chk("bp_hold", 32'(od[0]), 32'(held));
        ordy[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ind[0][7:0] = 8'(8'h90 + i);
            tick();
        end
        clr();
        tick();

        // Round-robin, all channels requesting single beats
        do_reset();
        log1.delete();
        inv[1] = 4'b1111; inl[1] = 4'b1111; ind[1] = 32'hD3C2B1A0;
        repeat (5) tick();
        clr();
        tick();
        chk("rr_all_len", 32'(log1.size()), 32'd5);
        for (int i = 0; i < 5; i++) chk($sformatf("rr_all%0d", i), 32'(log1[i]), 32'(i % 4));

        // Round-robin with ch1 idle
        do_reset();
        log1.delete();
        inv[1] = 4'b1101; inl[1] = 4'b1101; ind[1] = 32'h44332211;
        repeat (4) tick();
        clr();
        tick();
        chk("rr_skip_len", 32'(log1.size()), 32'd4);
        chk("rr_skip0", 32'(log1[0]), 32'd0);
        chk("rr_skip1", 32'(log1[1]), 32'd2);
        chk("rr_skip2", 32'(log1[2]), 32'd3);
        chk("rr_skip3", 32'(log1[3]), 32'd0);

        // Three-channel instance with out-of-range select
        sel[2] = 2'd3; inv[2] = 4'b0111; inl[2] = 4'b0111; ind[2] = 32'h00CCBBAA;
        repeat (3) tick();
        chk("n3_in_ready", 32'(irdy[2]), 32'd0);
        chk("n3_out_valid", 32'(ov[2]), 32'd0);
        clr();

        // Reset while beat 2 of a 4-beat ch2 packet is held
        inv[1] = 4'b0100; ind[1][23:16] = 8'hE1;
        tick();
        ind[1][23:16] = 8'hE2;
        tick();
        ordy[1] = 1'b0; inv[1] = 4'b0101; ind[1][23:16] = 8'hE3;
        tick();
        do_reset();
        log1.delete();
        inv[1] = 4'b0101; inl[1] = 4'b0101; ordy[1] = 1'b1;
        tick();
        clr();
        tick();
        chk("rst_first_len", 32'(log1.size()), 32'd1);
        chk("rst_first_ch", 32'(log1[0]), 32'd0);

        // Randomised traffic on all instances
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 3; k++) begin
                ind[k]  = $urandom;
                inv[k]  = 4'($urandom_range(0, 15));
                inl[k]  = 4'($urandom_range(0, 15));
                sel[k]  = 2'($urandom_range(0, 3));
                ordy[k] = ($urandom_range(0, 3) != 0);
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
